// File: rtl/pipe_stage_chain.sv
// Multi-stage payload pipeline with per-stage stall and flush, and a youngest-first forwarding lookup.
// Optional performance counters are enabled with `define PIPE_STAGE_CHAIN_PERF_CNT_EN.
module pipe_stage_chain #(
    parameter int DBITS               = 32,
    parameter int DEPTH               = 4,
    parameter int REG_INDEX_BIT_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [DBITS-1:0]                     in_data,
    input  logic [REG_INDEX_BIT_WIDTH-1:0]       in_rd,
    input  logic                                 in_wr_reg,
    input  logic [DEPTH-1:0]                     stall,
    input  logic [DEPTH-1:0]                     flush,
    output logic                                 in_ready,
    output logic [DEPTH-1:0]                     out_valid,
    output logic [DEPTH*DBITS-1:0]               out_data,
    output logic [DEPTH*REG_INDEX_BIT_WIDTH-1:0] out_rd,
    output logic [DEPTH-1:0]                     out_wr_reg,
    input  logic [REG_INDEX_BIT_WIDTH-1:0]       lookup_rs,
    output logic                                 fwd_hit,
    output logic [2:0]                           fwd_stage,
    output logic [DBITS-1:0]                     fwd_data
`ifdef PIPE_STAGE_CHAIN_PERF_CNT_EN
    ,
    output logic [31:0]                          bubble_cnt,
    output logic [31:0]                          flush_cnt
`endif
);

    logic [DEPTH-1:0]               stageValid;
    logic [DEPTH-1:0]               stageWr;
    logic [DBITS-1:0]               stageData [DEPTH];
    logic [REG_INDEX_BIT_WIDTH-1:0] stageRd   [DEPTH];

    logic [DEPTH-1:0]               nextValid;
    logic [DEPTH-1:0]               nextWr;
    logic [DBITS-1:0]               nextData  [DEPTH];
    logic [REG_INDEX_BIT_WIDTH-1:0] nextRd    [DEPTH];

    logic [DEPTH-1:0]               hold;

    // A stall freezes its own stage and everything upstream of it.
    always_comb begin
        hold = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hold[i] = |(stall >> i);
        end
    end

    assign in_ready = ~hold[0];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        nextValid = stageValid;
        nextWr    = stageWr;
        nextData  = stageData;
        nextRd    = stageRd;

        if (!hold[0]) begin
            nextValid[0] = in_valid;
            nextWr[0]    = in_wr_reg;
            nextData[0]  = in_data;
            nextRd[0]    = in_rd;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (!hold[i]) begin
                if (!hold[i-1]) begin
                    nextValid[i] = stageValid[i-1];
                    nextWr[i]    = stageWr[i-1];
                    nextData[i]  = stageData[i-1];
                    nextRd[i]    = stageRd[i-1];
                end else begin
                    // Upstream is frozen: insert a bubble, leaving payload bits as they were.
                    nextValid[i] = 1'b0;
                    nextWr[i]    = 1'b0;
                end
            end
        end

        // Flush kills liveness only; payload follows the normal hold/load path.
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i]) begin
                nextValid[i] = 1'b0;
                nextWr[i]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
        if (reset) begin
            // NOTE: payload registers are reset too, because they are directly visible on out_data/out_rd.
            stageValid <= '0;
            stageWr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stageData[i] <= '0;
                stageRd[i]   <= '0;
            end
        end else begin
            stageValid <= nextValid;
            stageWr    <= nextWr;
            stageData  <= nextData;
            stageRd    <= nextRd;
        end
    end

    always_comb begin
        out_data = '0;
        out_rd   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            out_data[i*DBITS +: DBITS]                             = stageData[i];
            out_rd[i*REG_INDEX_BIT_WIDTH +: REG_INDEX_BIT_WIDTH] = stageRd[i];
        end
    end

    assign out_valid  = stageValid;
    assign out_wr_reg = stageWr;

    // Scan oldest to youngest so the youngest matching writer is the last one assigned.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stage = 3'd0;
        fwd_data  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (stageValid[i] && stageWr[i] && (stageRd[i] == lookup_rs)) begin
                fwd_hit   = 1'b1;
                fwd_stage = 3'(i);
                fwd_data  = stageData[i];
            end
        end
    end

`ifdef PIPE_STAGE_CHAIN_PERF_CNT_EN
    logic bubbleAny;

    // A bubble enters stage i exactly when stage i moves but stage i-1 is held.
    assign bubbleAny = |(hold[DEPTH-2:0] & ~hold[DEPTH-1:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (bubbleAny) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
            if (|flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
